// File: rtl/merac_datapath.sv
// rtl/merac_datapath.sv - merac register file (16 x 8, two write / two read ports) plus combinational ALU
module merac_datapath #(
    parameter int WIDTH_WORD = 8,
    parameter int WIDTH_SEG  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we0,
    input  logic [WIDTH_SEG-1:0]  waddr0,
    input  logic [WIDTH_WORD-1:0] wdata0,
    input  logic                  we1,
    input  logic [WIDTH_SEG-1:0]  waddr1,
    input  logic [WIDTH_WORD-1:0] wdata1,
    input  logic [WIDTH_SEG-1:0]  raddr0,
    output logic [WIDTH_WORD-1:0] rdata0,
    input  logic [WIDTH_SEG-1:0]  raddr1,
    output logic [WIDTH_WORD-1:0] rdata1,
    input  logic                  alu_en,
    input  logic [2:0]            alu_func,
    output logic [WIDTH_WORD-1:0] alu_result,
    output logic                  alu_carry
);

    localparam int NUM_REGS = 2 ** WIDTH_SEG;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_NOT = 3'b100,
        ALU_MV  = 3'b101,
        ALU_EQ  = 3'b110,
        ALU_LT  = 3'b111
    } alu_func_e;

    logic [WIDTH_WORD-1:0] regs_q [NUM_REGS];

    // Port 1 is applied after port 0 so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (we0) begin
                regs_q[waddr0] <= wdata0;
            end
            if (we1) begin
                regs_q[waddr1] <= wdata1;
            end
        end
    end

    assign rdata0 = regs_q[raddr0];
    assign rdata1 = regs_q[raddr1];

    logic [WIDTH_WORD:0] sum_w;
    logic [WIDTH_WORD:0] diff_w;

    // The extra top bit is the carry for ADD and the borrow (A<B) for SUB.
    assign sum_w  = {1'b0, rdata0} + {1'b0, rdata1};
    assign diff_w = {1'b0, rdata0} - {1'b0, rdata1};

    always_comb begin
        alu_result = '0;
        alu_carry  = 1'b0;
        if (alu_en) begin
            case (alu_func_e'(alu_func))
                ALU_ADD: begin
                    alu_result = sum_w[WIDTH_WORD-1:0];
                    alu_carry  = sum_w[WIDTH_WORD];
                end
                ALU_SUB: begin
                    alu_result = diff_w[WIDTH_WORD-1:0];
                    alu_carry  = diff_w[WIDTH_WORD];
                end
                ALU_AND: alu_result = rdata0 & rdata1;
                ALU_OR:  alu_result = rdata0 | rdata1;
                ALU_NOT: alu_result = ~rdata0;
                ALU_MV:  alu_result = rdata0;
                ALU_EQ:  alu_carry  = (rdata0 == rdata1);
                ALU_LT:  alu_carry  = diff_w[WIDTH_WORD];
                default: begin
                    alu_result = '0;
                    alu_carry  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_merac_datapath.sv
// tb/tb_merac_datapath.sv - directed, table-driven checks of merac_datapath
module tb_merac_datapath;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       we0, we1;
    logic [3:0] waddr0, waddr1, raddr0, raddr1;
    logic [7:0] wdata0, wdata1;
    logic [7:0] rdata0, rdata1, alu_result;
    logic       alu_en;
    logic [2:0] alu_func;
    logic       alu_carry;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    merac_datapath #(.WIDTH_WORD(8), .WIDTH_SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we0       (we0),
        .waddr0    (waddr0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wdata1    (wdata1),
        .raddr0    (raddr0),
        .rdata0    (rdata0),
        .raddr1    (raddr1),
        .rdata1    (rdata1),
        .alu_en    (alu_en),
        .alu_func  (alu_func),
        .alu_result(alu_result),
        .alu_carry (alu_carry)
    );

    typedef struct {
        string      name;
        logic [3:0] ra0;
        logic [3:0] ra1;
        logic       en;
        logic [2:0] func;
        logic [7:0] exp_r0;
        logic [7:0] exp_r1;
        logic [7:0] exp_res;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] ra0, input logic [3:0] ra1,
                           input logic en, input logic [2:0] func, input logic [7:0] r0,
                           input logic [7:0] r1, input logic [7:0] res, input logic c);
        vec_t v;
        v.name = name; v.ra0 = ra0; v.ra1 = ra1; v.en = en; v.func = func;
        v.exp_r0 = r0; v.exp_r1 = r1; v.exp_res = res; v.exp_c = c;
        vecs.push_back(v);
    endtask

    initial begin
        // r3=08 r2=64 r4=FF r6=01 r7=7F r0=00
        add_vec("add",     3, 2, 1, 3'b000, 8'h08, 8'h64, 8'h6C, 1'b0);
        add_vec("sub",     3, 2, 1, 3'b001, 8'h08, 8'h64, 8'hA4, 1'b1);
        add_vec("and",     3, 2, 1, 3'b010, 8'h08, 8'h64, 8'h00, 1'b0);
        add_vec("or",      3, 2, 1, 3'b011, 8'h08, 8'h64, 8'h6C, 1'b0);
        add_vec("not",     3, 2, 1, 3'b100, 8'h08, 8'h64, 8'hF7, 1'b0);
        add_vec("mv",      3, 2, 1, 3'b101, 8'h08, 8'h64, 8'h08, 1'b0);
        add_vec("eq",      3, 2, 1, 3'b110, 8'h08, 8'h64, 8'h00, 1'b0);
        add_vec("lt",      3, 2, 1, 3'b111, 8'h08, 8'h64, 8'h00, 1'b1);
        add_vec("dis_add", 3, 2, 0, 3'b000, 8'h08, 8'h64, 8'h00, 1'b0);
        add_vec("dis_sub", 0, 6, 0, 3'b001, 8'h00, 8'h01, 8'h00, 1'b0);
        add_vec("add_wrap",4, 6, 1, 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1);
        add_vec("sub_ff1", 4, 6, 1, 3'b001, 8'hFF, 8'h01, 8'hFE, 1'b0);
        add_vec("and_ff1", 4, 6, 1, 3'b010, 8'hFF, 8'h01, 8'h01, 1'b0);
        add_vec("lt_ff1",  4, 6, 1, 3'b111, 8'hFF, 8'h01, 8'h00, 1'b0);
        add_vec("sub_wrap",0, 6, 1, 3'b001, 8'h00, 8'h01, 8'hFF, 1'b1);
        add_vec("lt_0_1",  0, 6, 1, 3'b111, 8'h00, 8'h01, 8'h00, 1'b1);
        add_vec("eq_7f",   7, 7, 1, 3'b110, 8'h7F, 8'h7F, 8'h00, 1'b1);
        add_vec("lt_7f",   7, 7, 1, 3'b111, 8'h7F, 8'h7F, 8'h00, 1'b0);
        add_vec("add_7f",  7, 7, 1, 3'b000, 8'h7F, 8'h7F, 8'hFE, 1'b0);
        add_vec("not_ff",  4, 0, 1, 3'b100, 8'hFF, 8'h00, 8'h00, 1'b0);

        rst_n = 1'b0; we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr0 = '0; raddr1 = '0; alu_en = 1'b0; alu_func = '0;
        tick();

        // Dirty a register, then reset with a write pending on r3.
        rst_n = 1'b1; we0 = 1'b1; waddr0 = 4'd3; wdata0 = 8'h99;
        tick();
        rst_n = 1'b0; wdata0 = 8'h77;
        tick();
        rst_n = 1'b1; we0 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr0 = 4'(i);
            raddr1 = 4'(15 - i);
            #1;
            chk($sformatf("reset_rd_%0d", i), {rdata0, rdata1}, 16'h0000);
        end
        chk("reset_alu", {7'd0, alu_carry, alu_result}, 16'h0000);

        // Dual write of the PC pair.
        we0 = 1'b1; waddr0 = 4'd14; wdata0 = 8'h12;
        we1 = 1'b1; waddr1 = 4'd15; wdata1 = 8'h34;
        tick();
        we0 = 1'b0; we1 = 1'b0; raddr0 = 4'd14; raddr1 = 4'd15;
        #1;
        chk("dual_write", {rdata0, rdata1}, 16'h1234);

        // Collision: port 1 wins.
        we0 = 1'b1; waddr0 = 4'd5; wdata0 = 8'hAA;
        we1 = 1'b1; waddr1 = 4'd5; wdata1 = 8'h55;
        tick();
        we0 = 1'b0; we1 = 1'b0; raddr0 = 4'd5;
        #1;
        chk("collision", {8'h00, rdata0}, 16'h0055);

        // Read-during-write: old value until the edge.
        we0 = 1'b1; waddr0 = 4'd2; wdata0 = 8'h10;
        tick();
        wdata0 = 8'h20; raddr0 = 4'd2;
        #1;
        chk("rdw_before", {8'h00, rdata0}, 16'h0010);
        tick();
        chk("rdw_after", {8'h00, rdata0}, 16'h0020);

        // Load ALU operands.
        we0 = 1'b1; we1 = 1'b1;
        waddr0 = 4'd3; wdata0 = 8'h08; waddr1 = 4'd2; wdata1 = 8'h64;
        tick();
        waddr0 = 4'd4; wdata0 = 8'hFF; waddr1 = 4'd6; wdata1 = 8'h01;
        tick();
        we1 = 1'b0; waddr0 = 4'd7; wdata0 = 8'h7F;
        tick();
        we0 = 1'b0;

        foreach (vecs[k]) begin
            raddr0 = vecs[k].ra0; raddr1 = vecs[k].ra1;
            alu_en = vecs[k].en; alu_func = vecs[k].func;
            #2;
            n_vec++;
            if ({rdata0, rdata1, alu_result, alu_carry} !==
                {vecs[k].exp_r0, vecs[k].exp_r1, vecs[k].exp_res, vecs[k].exp_c}) begin
                n_err++;
                $display("FAIL %s: got r0=%02h r1=%02h res=%02h c=%0b expected r0=%02h r1=%02h res=%02h c=%0b",
                         vecs[k].name, rdata0, rdata1, alu_result, alu_carry,
                         vecs[k].exp_r0, vecs[k].exp_r1, vecs[k].exp_res, vecs[k].exp_c);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/merac_datapath.md
# merac_datapath

Register file plus ALU for the merac 8-bit CPU core. It holds sixteen 8-bit registers with two write ports and two combinational read ports. Registers 14/15 hold the low/high bytes of the 16-bit program counter. A combinational ALU operates on the two read-port values. The core control FSM drives the register addresses and write enables and consumes the ALU result and carry.

## Interface
Parameters:
- WIDTH_WORD, 8, data width of each register and of the ALU.
- WIDTH_SEG, 4, register address width; the register count is 2**WIDTH_SEG.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- we0  in  1  write enable, port 0.
- waddr0  in  WIDTH_SEG  write address, port 0.
- wdata0  in  WIDTH_WORD  write data, port 0.
- we1  in  1  write enable, port 1.
- waddr1  in  WIDTH_SEG  write address, port 1.
- wdata1  in  WIDTH_WORD  write data, port 1.
- raddr0  in  WIDTH_SEG  read address, port 0.
- rdata0  out  WIDTH_WORD  register[raddr0]; also ALU operand A.
- raddr1  in  WIDTH_SEG  read address, port 1.
- rdata1  out  WIDTH_WORD  register[raddr1]; also ALU operand B.
- alu_en  in  1  ALU enable; connects to opcode bit 15.
- alu_func  in  3  ALU function; connects to opcode bits 14:12.
- alu_result  out  WIDTH_WORD  ALU result.
- alu_carry  out  1  ALU carry/flag.

## Operation
- Register file: 16 x 8-bit array.
- On a rising clk with rst_n=0, all registers clear to 0 and both writes are ignored.
- Otherwise, register[waddr0] <= wdata0 if we0, and register[waddr1] <= wdata1 if we1.
- Both ports may write in the same cycle; the core uses this for 16-bit pairs such as {r15,r14}.
- Same-address collision with both enables set: port 1 wins.
- Reads are combinational and asynchronous: rdata0 = register[raddr0], rdata1 = register[raddr1].
- No register is hardwired. Registers 14/15 are ordinary storage; their PC meaning belongs to the core.
- The ALU is purely combinational. A = rdata0, B = rdata1, both unsigned.
- alu_en=0: alu_result=0, alu_carry=0.
- alu_en=1, by alu_func:
  - 000 ADD: result = (A+B) mod 256; carry = bit 8 of the sum.
  - 001 SUB: result = (A−B) mod 256; carry = borrow (A<B).
  - 010 AND: result = A&B; carry=0.
  - 011 OR: result = A|B; carry=0.
  - 100 NOT: result = ~A; carry=0.
  - 101 MV: result = A; carry=0.
  - 110 EQ: result = 0; carry = (A==B).
  - 111 LT: result = 0; carry = (A<B).
- No X propagation. Every input combination yields a defined output.

## Timing
- Write latency is 1 cycle. Data written at edge N is visible on rdata from just after edge N.
- Read-during-write returns the old value until the edge; there is no write-through bypass.
- ALU outputs follow the read ports and alu_en/alu_func in the same cycle, with zero latency.
- Reset values: every register is 0, so rdata0=rdata1=0 after reset. alu_result and alu_carry are then per their formula; with alu_en=0 both are 0.
- Reset asserted mid-operation: the register clear takes priority over any pending write on that edge.
- Wrap-around: ADD 0xFF+0x01 gives result 0x00, carry 1. SUB 0x00−0x01 gives result 0xFF, carry 1.

## Test plan
- Reset then readback: hold rst_n=0 for one edge with we0=1 and waddr0=3. Then rdata of all 16 addresses is 0x00.
- Dual write: we0=we1=1, waddr0=14/wdata0=0x12, waddr1=15/wdata1=0x34. Next cycle raddr0=14 and raddr1=15 read 0x12 and 0x34.
- Collision: both ports write r5, port0=0xAA and port1=0x55. Then r5=0x55.
- Read-during-write: r2=0x10, then write r2=0x20 while raddr0=2. rdata0 is 0x10 before the edge and 0x20 after.
- ALU sweep with r3=0x08 and r2=0x64 (raddr0=3, raddr1=2), alu_en=1:
  - ADD gives 0x6C/0.
  - SUB gives 0xA4/1.
  - AND gives 0x00.
  - OR gives 0x6C.
  - NOT gives 0xF7.
  - MV gives 0x08.
  - EQ gives carry 0.
  - LT gives carry 1.
  - With alu_en=0, outputs are 0/0.
- Carry edge: A=0xFF, B=0x01. ADD gives 0x00/1. SUB gives 0xFE/0. EQ with A=B=0x7F gives carry 1.
